// File: rtl/typing_round_ctrl_pkg.sv
// Shared types and widths for the keypad typing round controller.
package typing_pkg;
  localparam int DIGIT_W = 4;
  localparam int TIME_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/typing_round_ctrl_round_timer.sv
// Loadable seconds down-counter; zero_o flags the tick that brings the count to 0.
import typing_pkg::*;

module round_timer (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [TIME_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic [TIME_W-1:0] count_o,
  output logic              zero_o
);
  logic [TIME_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // Asserted in the same cycle as the expiring tick so the FSM can leave PLAY on that edge.
  assign zero_o  = dec_i && !load_i && (count_q == TIME_W'(1));
endmodule

// File: rtl/typing_round_ctrl.sv
// Typing-test round controller: target word, cursor, score and round countdown.
// Optional build macro TYPING_PENALTY_EN: a wrong key costs one point and restarts the word.
import typing_pkg::*;

module typing_round_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int ROUND_SECS = 30,
  parameter int SCORE_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick_1hz,
  input  logic                          start,
  input  logic                          key_valid,
  input  logic [DIGIT_W-1:0]            key_code,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] rand_digits,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic [SCORE_W-1:0]            score,
  output logic [TIME_W-1:0]             time_left,
  output logic                          busy,
  output logic                          round_done,
  output logic [1:0]                    state_dbg
);
  localparam int CUR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CUR_W-1:0]      LAST_POS  = CUR_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_EN    = '1;
  localparam logic [SCORE_W-1:0]    SCORE_MAX = '1;

  state_t                          state_q;
  logic [DIGIT_W*NUM_DIGITS-1:0]   digit_val_q;
  logic [NUM_DIGITS-1:0]           digit_en_q;
  logic [SCORE_W-1:0]              score_q;
  logic [CUR_W-1:0]                cursor_q;
  logic                            busy_q;
  logic                            done_q;
  logic [DIGIT_W-1:0]              cur_digit;
  logic                            timer_zero;

  assign cur_digit = digit_val_q[cursor_q*DIGIT_W +: DIGIT_W];

  round_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (state_q == LOAD),
    .load_val_i (TIME_W'(ROUND_SECS)),
    .dec_i      ((state_q == PLAY) && tick_1hz),
    .count_o    (time_left),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      digit_val_q <= '0;
      digit_en_q  <= '0;
      score_q     <= '0;
      cursor_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          digit_val_q <= rand_digits;
          digit_en_q  <= ALL_EN;
          cursor_q    <= '0;
          score_q     <= '0;
          state_q     <= PLAY;
        end
        PLAY: begin
          if (key_valid) begin
            if (key_code == cur_digit) begin
              if (cursor_q == LAST_POS) begin
                score_q     <= (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;
                digit_val_q <= rand_digits;
                digit_en_q  <= ALL_EN;
                cursor_q    <= '0;
              end else begin
                digit_en_q[cursor_q] <= 1'b0;
                cursor_q             <= cursor_q + 1'b1;
              end
            end
`ifdef TYPING_PENALTY_EN
            else begin
              score_q    <= (score_q == '0) ? score_q : score_q - 1'b1;
              cursor_q   <= '0;
              digit_en_q <= ALL_EN;
            end
`endif
          end
          // Placed after the key handling so expiry overrides the display enables.
          if (timer_zero) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            digit_en_q <= '0;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign digit_val  = digit_val_q;
  assign digit_en   = digit_en_q;
  assign score      = score_q;
  assign busy       = busy_q;
  assign round_done = done_q;
  assign state_dbg  = state_q;
endmodule
